circular_rotate_sequencer: RTL and testbench
============================================

// Module: circular_rotate_sequencer
// PURPOSE
//  Multi-cycle controller that sequences circular (rotate) shifts of an N-bit word
//  by a runtime amount and direction. Uses one rotate-by-2^k stage per cycle,
//  processing the amount bits LSB-first, so large barrel rotators are not needed.
//  Sits between a valid/ready producer and a valid/ready consumer.
//  Holds one transaction in flight at a time.
// PARAMETERS
//  N   8            data width; must be a power of two, N >= 2
//  SW  $clog2(N)    amount width (derived; do not override)
// PORTS
//  clk         in   1    clock; all state updates on rising edge
//  rst         in   1    asynchronous, active-high reset
//  up_valid    in   1    request valid
//  up_ready    out  1    request accepted when up_valid & up_ready at a clk edge
//  up_data     in   N    word to rotate
//  up_amount   in   SW   rotate distance 0..N-1
//  up_dir      in   1    0 = rotate left (MSBs wrap to LSBs), 1 = rotate right
//  down_valid  out  1    result valid
//  down_ready  in   1    consumer accepts result when down_valid & down_ready
//  down_data   out  N    rotated word
//  busy        out  1    high whenever state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, SHIFT, DONE.
//  - Registers: data_q[N], amt_q[SW], dir_q, step_q (bit index 0..SW-1).
//  - Reset (async, any state): state=IDLE, data_q=0, amt_q=0, step_q=0;
//    up_ready=1, down_valid=0, down_data=0, busy=0.
//    Reset mid-operation discards the transaction; no partial result is emitted.
//  - up_ready = (state==IDLE). down_valid = (state==DONE). down_data = data_q.
//  - IDLE: on up_valid, capture up_data, up_amount and up_dir; set step_q=0.
//    If up_amount==0, go to DONE; otherwise go to SHIFT.
//  - SHIFT: each cycle, if amt_q[step_q]==1, rotate data_q by 2^step_q in dir_q;
//    otherwise hold data_q.
//    If step_q==SW-1 go to DONE; otherwise step_q++.
//    All SW bits are always visited, with no early exit.
//  - DONE: hold data_q stable while down_ready==0.
//    On down_ready, go to IDLE.
//  - Latency, from the accept edge to the first cycle with down_valid high:
//    1 edge if amount==0; otherwise 1+SW edges (N=8: 4 edges).
//  - Throughput: at most one result per (latency+1) cycles.
//    up_ready is low in DONE, even when down_ready is high.
//  - Rotation uses no shifts of width change: the result is always exactly N bits.
//  - Rotating by S then by T equals rotating by (S+T) mod N.
//  - up_* inputs are ignored outside IDLE.
//    Changing them mid-operation does not affect the result.
//  - N=2 edge case: SW=1, and the only nonzero rotation is a bit swap.
// TESTING
//  - Reset: assert rst asynchronously mid-SHIFT
//    -> up_ready=1, down_valid=0, down_data=0 immediately; no result is emitted afterwards.
//  - N=8, data 8'b1011_0001, amount 3, dir 0
//    -> down_data 8'b1000_1101, down_valid high 4 edges after accept.
//  - N=8, data 8'b1011_0001, amount 3, dir 1 -> down_data 8'b0011_0110.
//  - Amount 0, data 8'hA5
//    -> down_data 8'hA5, down_valid high 1 edge after accept.
//  - Backpressure: hold down_ready=0 for 5 cycles in DONE
//    -> down_data/down_valid stable, up_ready=0; one-cycle down_ready returns FSM to IDLE.
//  - Random sweep of all amounts 0..7 in both directions vs a software rotate model;
//    also toggle up_* while busy -> results unaffected, no lost or duplicated transactions.

Source files
------------

// File: rtl/circular_rotate_sequencer.sv
// Multi-cycle circular rotator: one rotate-by-2^k stage per cycle, amount bits LSB-first,
// with a valid/ready request port and a valid/ready result port, one transaction in flight.
module circular_rotate_sequencer #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [SW-1:0] up_amount,
  input  logic          up_dir,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SW-1:0] LAST_STEP = SW'(SW - 1);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_data;
  logic [N-1:0]  w_rot;
  logic [SW-1:0] r_amt;
  logic [SW-1:0] r_step;
  logic          r_dir;
  logic          w_take;
  int unsigned   w_dist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (up_valid) w_next = (up_amount == '0) ? DONE : SHIFT;
      SHIFT:   if (r_step == LAST_STEP) w_next = DONE;
      DONE:    if (down_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stage distance is 2^step <= N/2, so the complementary shift never reaches N.
  always_comb begin
    w_take = |(r_amt & (SW'(1) << r_step));
    w_dist = 32'd1 << r_step;
    if (r_dir) w_rot = (r_data >> w_dist) | (r_data << (N - w_dist));
    else       w_rot = (r_data << w_dist) | (r_data >> (N - w_dist));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_amt  <= '0;
      r_dir  <= 1'b0;
      r_step <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (up_valid) begin
            r_data <= up_data;
            r_amt  <= up_amount;
            r_dir  <= up_dir;
            r_step <= '0;
          end
        end
        SHIFT: begin
          if (w_take) r_data <= w_rot;
          if (r_step != LAST_STEP) r_step <= r_step + SW'(1);
        end
        default: ;
      endcase
    end
  end

  assign up_ready   = (r_state == IDLE);
  assign down_valid = (r_state == DONE);
  assign down_data  = r_data;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_circular_rotate_sequencer.sv
// Self-checking bench for circular_rotate_sequencer: directed cases, randomized sweep
// against an index-mapping rotate model, async reset, backpressure and an N=2 instance.
module tb_circular_rotate_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [2:0] up_amount;
  logic       up_dir;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic       busy;

  logic       n2_up_valid;
  logic       n2_up_ready;
  logic [1:0] n2_up_data;
  logic [0:0] n2_up_amount;
  logic       n2_up_dir;
  logic       n2_down_valid;
  logic       n2_down_ready;
  logic [1:0] n2_down_data;
  logic       n2_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  circular_rotate_sequencer #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amount  (up_amount),
    .up_dir     (up_dir),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .busy       (busy)
  );

  circular_rotate_sequencer #(.N(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (n2_up_valid),
    .up_ready   (n2_up_ready),
    .up_data    (n2_up_data),
    .up_amount  (n2_up_amount),
    .up_dir     (n2_up_dir),
    .down_valid (n2_down_valid),
    .down_ready (n2_down_ready),
    .down_data  (n2_down_data),
    .busy       (n2_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Left rotate by s sends bit i to bit (i+s) mod W; right by s equals left by W-s.
  function automatic logic [7:0] model_rot(input logic [7:0] d, input int amt, input logic dr);
    logic [7:0] r;
    int sh;
    sh = dr ? (8 - amt) % 8 : amt % 8;
    for (int i = 0; i < 8; i++) r[(i + sh) % 8] = d[i];
    return r;
  endfunction

  task automatic run_txn(input logic [7:0] d, input logic [2:0] a, input logic dr,
                         input bit garble, input int hold, input string tag);
    logic [7:0] exp;
    int lat;
    int exp_lat;
    exp     = model_rot(d, int'(a), dr);
    exp_lat = (a == 3'd0) ? 1 : 4;
    up_valid   = 1'b1;
    up_data    = d;
    up_amount  = a;
    up_dir     = dr;
    down_ready = 1'b0;
    check({tag, "/up_ready_idle"}, 32'(up_ready), 32'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (garble && !down_valid) begin
        up_valid   = 1'($urandom);
        up_data    = 8'($urandom);
        up_amount  = 3'($urandom);
        up_dir     = 1'($urandom);
        down_ready = 1'($urandom);
      end else begin
        up_valid   = 1'b0;
        down_ready = 1'b0;
      end
    end while (!down_valid && lat < 20);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/down_valid"}, 32'(down_valid), 32'd1);
    check({tag, "/down_data"}, 32'(down_data), 32'(exp));
    check({tag, "/up_ready_done"}, 32'(up_ready), 32'd0);
    check({tag, "/busy_done"}, 32'(busy), 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check({tag, "/hold_data"}, 32'(down_data), 32'(exp));
      check({tag, "/hold_valid"}, 32'(down_valid), 32'd1);
      check({tag, "/hold_up_ready"}, 32'(up_ready), 32'd0);
    end
    down_ready = 1'b1;
    @(negedge clk);
    down_ready = 1'b0;
    check({tag, "/idle_up_ready"}, 32'(up_ready), 32'd1);
    check({tag, "/idle_down_valid"}, 32'(down_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [7:0] rd;
    logic [2:0] ra;

    rst = 1'b1;
    up_valid = 1'b0; up_data = '0; up_amount = '0; up_dir = 1'b0; down_ready = 1'b0;
    n2_up_valid = 1'b0; n2_up_data = '0; n2_up_amount = '0; n2_up_dir = 1'b0; n2_down_ready = 1'b0;
    #1;
    check("reset/up_ready", 32'(up_ready), 32'd1);
    check("reset/down_valid", 32'(down_valid), 32'd0);
    check("reset/down_data", 32'(down_data), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_txn(8'b1011_0001, 3'd3, 1'b0, 1'b0, 0, "rotl3");
    run_txn(8'b1011_0001, 3'd3, 1'b1, 1'b0, 0, "rotr3");
    run_txn(8'hA5, 3'd0, 1'b0, 1'b0, 0, "amt0");
    run_txn(8'h3C, 3'd5, 1'b1, 1'b0, 5, "backpressure");

    // Async reset in the middle of SHIFT: outputs clear at once, nothing emitted afterwards.
    up_valid = 1'b1; up_data = 8'hF0; up_amount = 3'd7; up_dir = 1'b0;
    @(posedge clk);
    @(negedge clk);
    up_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midreset/up_ready", 32'(up_ready), 32'd1);
    check("midreset/down_valid", 32'(down_valid), 32'd0);
    check("midreset/down_data", 32'(down_data), 32'd0);
    check("midreset/busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (down_valid) seen = 1'b1;
    end
    check("midreset/no_result", 32'(seen), 32'd0);

    for (int a = 0; a < 8; a++) begin
      for (int dr = 0; dr < 2; dr++) begin
        rd = 8'($urandom);
        run_txn(rd, 3'(a), 1'(dr), 1'($urandom), 0, $sformatf("sweep_a%0d_d%0d", a, dr));
      end
    end
    for (int k = 0; k < 12; k++) begin
      rd = 8'($urandom);
      ra = 3'($urandom);
      run_txn(rd, ra, 1'($urandom), 1'b1, int'($urandom_range(2)), $sformatf("rand%0d", k));
    end

    // N=2: the only nonzero rotation swaps the two bits, after 2 edges.
    for (int dr = 0; dr < 2; dr++) begin
      n2_up_valid = 1'b1; n2_up_data = 2'b10; n2_up_amount = 1'b1; n2_up_dir = 1'(dr);
      @(posedge clk);
      @(negedge clk);
      n2_up_valid = 1'b0;
      check($sformatf("n2_d%0d/lat1_valid", dr), 32'(n2_down_valid), 32'd0);
      @(negedge clk);
      check($sformatf("n2_d%0d/valid", dr), 32'(n2_down_valid), 32'd1);
      check($sformatf("n2_d%0d/data", dr), 32'(n2_down_data), 32'h1);
      n2_down_ready = 1'b1;
      @(negedge clk);
      n2_down_ready = 1'b0;
      check($sformatf("n2_d%0d/idle", dr), 32'(n2_up_ready), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
